// File: rtl/mulmod_reduce_seq_if.sv
// Handshake bundle for the Goldilocks reduction sequencer.
//   in_valid / in_ready / mul_in    : product intake (producer -> reducer)
//   out_valid / out_ready / res_out : canonical residue (reducer -> consumer)
// master = producer/consumer side, slave = reducer side.
interface mulmod_reduce_seq_if #(
    parameter int P_WIDTH  = 64,
    parameter int PD_WIDTH = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [PD_WIDTH-1:0] mul_in;
    logic                out_valid;
    logic                out_ready;
    logic [P_WIDTH-1:0]  res_out;

    modport master (
        output in_valid, mul_in, out_ready,
        input  in_ready, out_valid, res_out
    );

    modport slave (
        input  in_valid, mul_in, out_ready,
        output in_ready, out_valid, res_out
    );
endinterface

// File: rtl/mulmod_reduce_seq.sv
// Multi-cycle reduction of a 128-bit product modulo P = 2^64 - 2^32 + 1.
// The product is split into 32-bit words x3..x0 and folded using
// 2^64 = 2^32 - 1 and 2^96 = -1 (mod P); two fixed correction steps then
// bring the value into [0, P). One reduction in flight, fixed latency.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of mulmod_reduce_seq_if (in/out valid-ready, mul_in, res_out)
//   busy : high whenever the sequencer is not idle (registered)
module mulmod_reduce_seq #(
    parameter int                 P_WIDTH  = 64,
    parameter int                 W_WIDTH  = 32,
    parameter int                 PD_WIDTH = 128,
    parameter logic [P_WIDTH-1:0] MODULUS  = 64'hFFFF_FFFF_0000_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    mulmod_reduce_seq_if.slave   bus,
    output logic                 busy
);
    // Three guard bits: accumulated value reaches 2^65 and the SUB step can go negative.
    localparam int A_WIDTH = P_WIDTH + 3;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        SUB,
        FIX1,
        FIX2,
        DONE
    } state_t;

    state_t               state;
    logic [W_WIDTH-1:0]   x0, x1, x2, x3;
    logic [A_WIDTH-1:0]   acc;
    logic [A_WIDTH-1:0]   acc_fixed;
    logic [A_WIDTH-1:0]   mod_ext;

    function automatic logic [A_WIDTH-1:0] ext(input logic [W_WIDTH-1:0] w);
        return A_WIDTH'(w);
    endfunction

    assign mod_ext = A_WIDTH'(MODULUS);

    // One correction step: the MSB of acc is the two's-complement sign.
    always_comb begin
        acc_fixed = acc;
        if (acc[A_WIDTH-1]) begin
            acc_fixed = acc + mod_ext;
        end else if (acc >= mod_ext) begin
            acc_fixed = acc - mod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            x0            <= '0;
            x1            <= '0;
            x2            <= '0;
            x3            <= '0;
            acc           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.res_out   <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        x0           <= bus.mul_in[0 +: W_WIDTH];
                        x1           <= bus.mul_in[W_WIDTH +: W_WIDTH];
                        x2           <= bus.mul_in[2*W_WIDTH +: W_WIDTH];
                        x3           <= bus.mul_in[PD_WIDTH-W_WIDTH +: W_WIDTH];
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= ACC;
                    end
                end
                ACC: begin
                    // x2*2^64 folds to x2*(2^32 - 1).
                    acc   <= ext(x0) + (ext(x1) << W_WIDTH) + (ext(x2) << W_WIDTH) - ext(x2);
                    state <= SUB;
                end
                SUB: begin
                    // x3*2^96 folds to -x3.
                    acc   <= acc - ext(x3);
                    state <= FIX1;
                end
                FIX1: begin
                    acc   <= acc_fixed;
                    state <= FIX2;
                end
                FIX2: begin
                    acc   <= acc_fixed;
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.res_out   <= acc[P_WIDTH-1:0];
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mulmod_reduce_seq.sv
// Bench for mulmod_reduce_seq: directed vectors, backpressure, mid-flight
// reset and a randomized scoreboard against a plain x % P reference.
module tb_mulmod_reduce_seq;
    localparam logic [63:0] P = 64'hFFFF_FFFF_0000_0001;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    mulmod_reduce_seq_if #(.P_WIDTH(64), .PD_WIDTH(128)) bus ();

    mulmod_reduce_seq #(
        .P_WIDTH (64),
        .W_WIDTH (32),
        .PD_WIDTH(128),
        .MODULUS (64'hFFFF_FFFF_0000_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    function automatic logic [63:0] ref_mod(input logic [127:0] x);
        logic [127:0] p128;
        p128 = {64'd0, P};
        return 64'(x % p128);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one transaction; leaves the caller at #1 after the output handshake edge.
    task automatic do_txn(input logic [127:0] x, input int stall, input bit junk,
                          output logic [63:0] res, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        res = '0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.mul_in   = x;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0; bus.in_valid = 1'b0; return;
        end
        @(posedge clk); #1;
        if (junk) bus.mul_in = rand128();
        else bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.out_valid) begin
            ok = 1'b0; bus.in_valid = 1'b0; return;
        end
        repeat (stall) begin
            @(posedge clk); #1;
        end
        res = bus.res_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.mul_in   = 128'h5;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        total_cnt += 4;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        if (bus.res_out !== 64'd0) $display("FAIL reset_res_out got %h want 0", bus.res_out);
        else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [127:0] xs[6];
        logic [63:0]  es[6];
        logic [127:0] pm1;
        logic [63:0]  res;
        int           lat;
        bit           ok;
        pm1 = {64'd0, P - 64'd1};
        xs[0] = 128'h5;                        es[0] = 64'h5;
        xs[1] = {64'd0, P};                    es[1] = 64'h0;
        xs[2] = 128'h1 << 64;                  es[2] = 64'h0000_0000_FFFF_FFFF;
        xs[3] = 128'h1 << 96;                  es[3] = 64'hFFFF_FFFF_0000_0000;
        xs[4] = pm1 * pm1;                     es[4] = 64'h1;
        xs[5] = '1;                            es[5] = 64'hFFFF_FFFE_0000_0000;
        for (int i = 0; i < 6; i++) begin
            do_txn(xs[i], 0, 1'b0, res, lat, ok);
            total_cnt += 4;
            if (!ok) $display("FAIL directed%0d_handshake timed out", i);
            else pass_cnt++;
            if (lat !== 5) $display("FAIL directed%0d_latency got %0d want 5", i, lat);
            else pass_cnt++;
            if (res !== es[i]) $display("FAIL directed%0d_res got %h want %h", i, res, es[i]);
            else pass_cnt++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
                $display("FAIL directed%0d_release got valid=%b ready=%b want 0/1",
                         i, bus.out_valid, bus.in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] x;
        logic [63:0]  r0;
        int           n;
        bit           stable;
        x = rand128();
        bus.in_valid = 1'b1;
        bus.mul_in   = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        total_cnt += 3;
        if (!bus.out_valid) $display("FAIL bp_out_valid timed out");
        else pass_cnt++;
        r0 = bus.res_out;
        if (r0 !== ref_mod(x)) $display("FAIL bp_res got %h want %h", r0, ref_mod(x));
        else pass_cnt++;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.res_out !== r0 || bus.in_ready !== 1'b0 || busy !== 1'b1)
                stable = 1'b0;
        end
        if (!stable) $display("FAIL bp_hold got valid=%b res=%h ready=%b want 1/%h/0",
                              bus.out_valid, bus.res_out, bus.in_ready, r0);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [127:0] x;
        logic [63:0]  res;
        int           lat;
        bit           ok;
        bit           seen;
        bus.in_valid = 1'b1;
        bus.mul_in   = rand128();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt += 5;
        if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy);
        else pass_cnt++;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        if (seen) $display("FAIL midrst_no_result got out_valid=1 want 0");
        else pass_cnt++;
        x = rand128();
        do_txn(x, 1, 1'b0, res, lat, ok);
        if (!ok || res !== ref_mod(x)) $display("FAIL midrst_recover got %h want %h", res, ref_mod(x));
        else pass_cnt++;
    endtask

    task automatic test_random(input int count);
        logic [127:0] x;
        logic [63:0]  res;
        logic [63:0]  a, b;
        logic [31:0]  w[4];
        int           lat;
        int           stall;
        bit           ok;
        for (int i = 0; i < count; i++) begin
            case ($urandom_range(0, 3))
                0: x = rand128();
                1: begin
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    x = {64'd0, a} * {64'd0, b};
                end
                2: x = {64'd0, P} * 128'($urandom) + 128'($urandom_range(0, 3)) - 128'd2;
                default: begin
                    for (int j = 0; j < 4; j++) begin
                        case ($urandom_range(0, 3))
                            0: w[j] = 32'h0;
                            1: w[j] = 32'hFFFF_FFFF;
                            2: w[j] = 32'h1;
                            default: w[j] = $urandom;
                        endcase
                    end
                    x = {w[3], w[2], w[1], w[0]};
                end
            endcase
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_txn(x, stall, 1'($urandom_range(0, 1)), res, lat, ok);
            total_cnt++;
            if (!ok || res !== ref_mod(x))
                $display("FAIL random%0d_res x=%h got %h want %h ok=%b", i, x, res, ref_mod(x), ok);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mul_in    = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random(5000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
